link_init_fsm: RTL
==================

# link_init_fsm

Parametrised link-initialisation controller between the FTDI byte interface and the sample datapath. The host sends a configurable magic string; the block answers with a configurable ID string. The host then sends a 16-bit sample rate, which is checked against the 8-entry supported-rate table and answered with "OK" or "ERR". On success the block raises `init_rdy` and releases the byte stream to the datapath; it re-enters the handshake only on `rst` or `rearm`.

## Interface
- `MAGIC_LEN`, default 3: magic string length in bytes (1..8).
- `MAGIC`, default "UTN": magic string, 8*MAGIC_LEN bits, first byte in the MSBs.
- `REPLY_LEN`, default 5: ID reply length in bytes (1..8).
- `REPLY`, default "UTNv2": ID reply, 8*REPLY_LEN bits, first byte in the MSBs.
- `TIMEOUT_CYC`, default 24'd12_000_000: maximum idle cycles between host bytes after the magic string has matched.
- `clk`  in  1: clock.
- `rst`  in  1: reset; synchronous, active-high.
- `rx_data`  in  8: byte from the FTDI receive path.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: block accepts a byte this cycle.
- `tx_data`  out  8: byte to the FTDI transmit path.
- `tx_valid`  out  1: `tx_data` is valid.
- `tx_ready`  in  1: transmit path consumes the byte this cycle.
- `rearm`  in  1: one-cycle pulse; leaves READY and restarts the handshake.
- `init_rdy`  out  1: handshake complete; datapath owns the byte stream.
- `rate_sel`  out  3: index of the accepted rate (0=48000, 1=44100, 2=32000, 3=24000, 4=22050, 5=16000, 6=11025, 7=8000 Hz).
- `rate_hz`  out  16: accepted rate value in Hz.
- `timeout`  out  1: one-cycle pulse when an idle timeout aborts the handshake.

## Operation
- Byte transfer rules:
  - An rx byte transfers on a cycle where `rx_valid && rx_ready`.
  - A tx byte transfers on a cycle where `tx_valid && tx_ready`.
  - `tx_data` stays stable while `tx_valid` is high and the byte has not transferred.
- States:
  - HUNT: `rx_ready`=1. Compares each byte with `MAGIC[idx]`.
    - Match: idx++. When the last byte matches, go to ID.
    - Mismatch: idx := (byte == `MAGIC[0]`) ? 1 : 0.
  - ID: `rx_ready`=0. Sends the REPLY bytes in order, then goes to RATE.
  - RATE: `rx_ready`=1. Takes 2 bytes, LSB first, into `samp_rate`, then goes to CHECK.
  - CHECK: one cycle. Compares `samp_rate` against the table.
    - Hit: latch `rate_sel` and `rate_hz`, send "OK", go to READY.
    - Miss: send "ERR", go to HUNT with idx=0.
  - ACK: sends the OK or ERR bytes.
  - READY: `init_rdy`=1, `rx_ready`=0, `tx_valid`=0.
    - `rearm` goes to HUNT, clears `init_rdy`, and holds `rate_sel`/`rate_hz`.
- Timeout:
  - A counter is active in ID, RATE and ACK. It reloads on every byte transfer in either direction.
  - When it reaches `TIMEOUT_CYC` with no transfer, the block pulses `timeout` and goes to HUNT with idx=0. Any partial `samp_rate` is discarded.
- `rearm` in any state other than READY is ignored.

## Timing
- Reset values:
  - `rx_ready`=0, `tx_valid`=0, `tx_data`=0, `init_rdy`=0, `rate_sel`=0, `rate_hz`=0, `timeout`=0.
  - State=HUNT, idx=0.
  - `rx_ready` rises 1 cycle after `rst` deasserts.
- All outputs are registered.
- First ID byte: `tx_valid` asserts the cycle after the last magic byte transfers.
- Consecutive tx bytes: the next byte is presented the cycle after a transfer, so back-to-back with `tx_ready` held high.
- Rate check: the cycle after the 2nd rate byte transfers is CHECK. The first ACK byte is valid on the following cycle.
- `init_rdy` asserts the cycle after the final 'K' transfers.
- `rst` mid-operation overrides everything on the next edge, including any byte in flight. An unsent tx byte is dropped, not completed.
- In ACK/ID, `rx_valid` is ignored (`rx_ready`=0); the host must not send early.
- `timeout` and a transfer in the same cycle: the transfer wins, the counter reloads, and `timeout` is not pulsed.

## Test plan
1. Full handshake:
   - Stimulus: `tx_ready`=1, rx "UTN" then 0x80,0xBB (48000).
   - Response: tx "UTNv2", then "OK". `init_rdy`=1, `rate_sel`=0, `rate_hz`=48000.
2. Magic resync:
   - Stimulus: rx "UUTN".
   - Response: ID reply is sent. Then rx "UXTN".
   - Response: no reply; HUNT with idx=0.
3. Invalid rate:
   - Stimulus: after the ID reply, rx 0x10,0x27 (10000).
   - Response: tx "ERR"; `init_rdy`=0; back in HUNT.
   - Then a repeat of scenario 1 with 0x40,0x1F (8000) must give `rate_sel`=7.
4. Backpressure:
   - Stimulus: `tx_ready` toggled 1/0 every cycle during the ID reply.
   - Response: all 5 bytes arrive in order, with `tx_data` stable while stalled.
5. Timeout:
   - Stimulus: `TIMEOUT_CYC`=100; after the ID reply, send 1 rate byte and then idle.
   - Response: `timeout` pulses exactly 100 cycles after the last transfer; state returns to HUNT.
6. Reset and rearm:
   - `rst` during the 3rd ID byte: all outputs return to their reset values with no further tx.
   - `rearm` in READY: `init_rdy` falls the next cycle, `rate_sel` is held, and the block accepts a new "UTN".

Source files
------------

// File: rtl/link_init_fsm.sv
// link_init_fsm: host magic / ID reply / sample-rate handshake that gates the
// FTDI byte stream over to the sample datapath once a supported rate is agreed.
module link_init_fsm #(
    parameter int                     MAGIC_LEN   = 3,
    parameter logic [8*MAGIC_LEN-1:0] MAGIC       = "UTN",
    parameter int                     REPLY_LEN   = 5,
    parameter logic [8*REPLY_LEN-1:0] REPLY       = "UTNv2",
    parameter logic [23:0]            TIMEOUT_CYC = 24'd12_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        rearm,
    output logic        init_rdy,
    output logic [2:0]  rate_sel,
    output logic [15:0] rate_hz,
    output logic        timeout
);
    typedef enum logic [2:0] {HUNT, ID, RATE, CHECK, ACK, READY} state_t;
    localparam logic [127:0] RATE_TBL = {16'd8000, 16'd11025, 16'd16000, 16'd22050,
                                         16'd24000, 16'd32000, 16'd44100, 16'd48000};
    // Byte i of a string of len bytes whose first byte sits in the MSBs.
    function automatic logic [7:0] pick(input logic [63:0] s, input int len, input int i);
        return 8'(s >> (8 * (len - 1 - i)));
    endfunction
    state_t      r_state, w_state;
    logic [2:0]  r_idx, w_idx;
    logic [15:0] r_samp, w_samp;
    logic        r_ack_err, w_ack_err;
    logic [23:0] r_cnt, w_cnt;
    logic [7:0]  r_tx_data, w_tx_data;
    logic        r_tx_valid, w_tx_valid;
    logic        r_rx_ready, w_rx_ready;
    logic        r_init_rdy, w_init_rdy;
    logic [2:0]  r_rate_sel, w_rate_sel;
    logic [15:0] r_rate_hz, w_rate_hz;
    logic        r_timeout, w_timeout;
    logic        w_rx_xfer, w_tx_xfer, w_xfer, w_hit;
    logic [2:0]  w_hit_sel;
    logic [63:0] w_ack_str;
    assign rx_ready = r_rx_ready;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign init_rdy = r_init_rdy;
    assign rate_sel = r_rate_sel;
    assign rate_hz  = r_rate_hz;
    assign timeout  = r_timeout;
    assign w_rx_xfer = rx_valid && r_rx_ready;
    assign w_tx_xfer = r_tx_valid && tx_ready;
    assign w_xfer    = w_rx_xfer || w_tx_xfer;
    assign w_ack_str = r_ack_err ? 64'("ERR") : 64'("OK");
    always_comb begin
        w_hit     = 1'b0;
        w_hit_sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_samp == RATE_TBL[16*i +: 16]) begin
                w_hit     = 1'b1;
                w_hit_sel = 3'(i);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HUNT;
            r_idx      <= '0;
            r_samp     <= '0;
            r_ack_err  <= 1'b0;
            r_cnt      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b0;
            r_init_rdy <= 1'b0;
            r_rate_sel <= '0;
            r_rate_hz  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_samp     <= w_samp;
            r_ack_err  <= w_ack_err;
            r_cnt      <= w_cnt;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_rx_ready <= w_rx_ready;
            r_init_rdy <= w_init_rdy;
            r_rate_sel <= w_rate_sel;
            r_rate_hz  <= w_rate_hz;
            r_timeout  <= w_timeout;
        end
    end
    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_samp     = r_samp;
        w_ack_err  = r_ack_err;
        w_cnt      = (w_xfer || r_state == HUNT || r_state == READY) ? 24'd0 : r_cnt + 24'd1;
        w_tx_data  = r_tx_data;
        w_tx_valid = r_tx_valid;
        w_rx_ready = r_rx_ready;
        w_init_rdy = r_init_rdy;
        w_rate_sel = r_rate_sel;
        w_rate_hz  = r_rate_hz;
        w_timeout  = 1'b0;
        case (r_state)
            HUNT: begin
                w_rx_ready = 1'b1;
                w_tx_valid = 1'b0;
                if (w_rx_xfer) begin
                    if (rx_data != pick(64'(MAGIC), MAGIC_LEN, int'(r_idx)))
                        w_idx = (rx_data == pick(64'(MAGIC), MAGIC_LEN, 0)) ? 3'd1 : 3'd0;
                    else if (int'(r_idx) != MAGIC_LEN - 1)
                        w_idx = r_idx + 3'd1;
                    else begin
                        w_state    = ID;
                        w_idx      = 3'd0;
                        w_rx_ready = 1'b0;
                        w_tx_valid = 1'b1;
                        w_tx_data  = pick(64'(REPLY), REPLY_LEN, 0);
                    end
                end
            end
            ID: begin
                if (w_tx_xfer) begin
                    if (int'(r_idx) != REPLY_LEN - 1) begin
                        w_idx     = r_idx + 3'd1;
                        w_tx_data = pick(64'(REPLY), REPLY_LEN, int'(r_idx) + 1);
                    end else begin
                        w_state    = RATE;
                        w_idx      = 3'd0;
                        w_tx_valid = 1'b0;
                        w_rx_ready = 1'b1;
                    end
                end
            end
            RATE: begin
                if (w_rx_xfer) begin
                    if (r_idx == 3'd0) begin
                        w_samp[7:0] = rx_data;
                        w_idx       = 3'd1;
                    end else begin
                        w_samp[15:8] = rx_data;
                        w_state      = CHECK;
                        w_idx        = 3'd0;
                        w_rx_ready   = 1'b0;
                    end
                end
            end
            CHECK: begin
                w_state    = ACK;
                w_idx      = 3'd0;
                w_ack_err  = !w_hit;
                w_tx_valid = 1'b1;
                w_tx_data  = w_hit ? "O" : "E";
                w_rate_sel = w_hit ? w_hit_sel : r_rate_sel;
                w_rate_hz  = w_hit ? r_samp : r_rate_hz;
            end
            ACK: begin
                if (w_tx_xfer) begin
                    if (int'(r_idx) != (r_ack_err ? 2 : 1)) begin
                        w_idx     = r_idx + 3'd1;
                        w_tx_data = pick(w_ack_str, r_ack_err ? 3 : 2, int'(r_idx) + 1);
                    end else begin
                        w_state    = r_ack_err ? HUNT : READY;
                        w_idx      = 3'd0;
                        w_tx_valid = 1'b0;
                        w_rx_ready = r_ack_err;
                        w_init_rdy = !r_ack_err;
                    end
                end
            end
            READY: begin
                w_rx_ready = 1'b0;
                w_tx_valid = 1'b0;
                if (rearm) begin
                    w_state    = HUNT;
                    w_idx      = 3'd0;
                    w_init_rdy = 1'b0;
                    w_rx_ready = 1'b1;
                end
            end
            default: w_state = HUNT;
        endcase
        // A transfer in the same cycle always wins over an expiring idle timer.
        if ((r_state == ID || r_state == RATE || r_state == ACK) && !w_xfer &&
            r_cnt >= TIMEOUT_CYC - 24'd1) begin
            w_state    = HUNT;
            w_idx      = 3'd0;
            w_samp     = '0;
            w_tx_valid = 1'b0;
            w_rx_ready = 1'b1;
            w_timeout  = 1'b1;
        end
    end
endmodule
